// File: rtl/demux_defs.sv
// Shared constants for the 1:4 router and the 4:1 mux path.
// Channel indices and the select-to-one-hot helper live here.
package demux_defs;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] CH0 = 2'd0;
  localparam logic [SEL_W-1:0] CH1 = 2'd1;
  localparam logic [SEL_W-1:0] CH2 = 2'd2;
  localparam logic [SEL_W-1:0] CH3 = 2'd3;

  function automatic logic [NUM_CH-1:0] sel_onehot(
    input logic [SEL_W-1:0] sel
  );
    logic [NUM_CH-1:0] oh;
    oh = '0;
    unique case (sel)
      CH0: oh[0] = 1'b1;
      CH1: oh[1] = 1'b1;
      CH2: oh[2] = 1'b1;
      CH3: oh[3] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel FIFO with occupancy count; read data is
// forced to zero whenever the FIFO is empty.
module chan_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  // Guard here too so a misbehaving caller cannot corrupt state.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_q];

endmodule

// File: rtl/demux_1x4_router.sv
// 1:4 word router: select decoder, four channel FIFOs
// and a saturating stall counter.
module demux_1x4_router
  import demux_defs::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     d1,
  input  logic                     d0,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] sel_oh;
  logic [DATA_W-1:0] rdata [NUM_CH];
  logic              accept;
  logic              stall_hit;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign sel    = {d1, d0};
  assign sel_oh = sel_onehot(sel);

  // Full blocks input even if the channel pops this
  // cycle, keeping out_ready off the in_ready path.
  assign in_ready = en & ~full[sel];
  assign accept   = in_valid & in_ready;
  assign push     = accept ? sel_oh : '0;

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign busy      = |out_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .wdata (in_data),
      .pop   (pop[g]),
      .rdata (rdata[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
    assign out_data[g*DATA_W +: DATA_W] = rdata[g];
  end

  assign stall_hit = in_valid & en & full[sel];

  always_comb begin
    stall_d = stall_q;
    if (stall_hit && (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_demux_1x4_router.sv
// Directed bench for demux_1x4_router.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_demux_1x4_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        d1, d0;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [7:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1x4_router #(.DATA_W(8), .DEPTH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .d1        (d1),
    .d0        (d0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int k);
    {d1, d0} = 2'(k);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; set_sel(0);
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 4'b0;
    tick(); tick();
    #1;
    checks++;
    if (out_valid !== 4'b0) begin
      errors++; $display("FAIL rst_out_valid got %b want 0000", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (stall_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_stall got %0d want 0", stall_cnt);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL rst_out_data got %h want 0", out_data);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_routing();
    logic [7:0]  w;
    logic [31:0] exp_data;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      w = 8'hA0 + 8'(k);
      set_sel(k); in_data = w; in_valid = 1'b1;
      tick();
      exp_data = 32'(w) << (8 * k);
      #1;
      checks++;
      if (out_valid !== (4'b1 << k)) begin
        errors++;
        $display("FAIL route_valid ch%0d got %b want %b", k, out_valid, 4'b1 << k);
      end
      checks++;
      if (out_data !== exp_data) begin
        errors++;
        $display("FAIL route_data ch%0d got %h want %h", k, out_data, exp_data);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL route_drain got v=%b busy=%b want 0000/0", out_valid, busy);
    end
  endtask

  task automatic test_fill_stall();
    out_ready = 4'b0; set_sel(2); in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_in_ready got %b want 0", in_ready);
    end
    tick(); tick();
    checks++;
    if (stall_cnt !== 8'd2) begin
      errors++; $display("FAIL fill_stall got %0d want 2", stall_cnt);
    end
    set_sel(1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL fill_other_ready got %b want 1", in_ready);
    end
    set_sel(2); out_ready = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_data[23:16] !== 8'h11) begin
      errors++;
      $display("FAIL fill_head1 got rdy=%b d=%h want 0/11", in_ready, out_data[23:16]);
    end
    tick();
    checks++;
    if (out_data[23:16] !== 8'h22 || stall_cnt !== 8'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_head2 got d=%h st=%0d rdy=%b want 22/3/1",
               out_data[23:16], stall_cnt, in_ready);
    end
    tick();
    checks++;
    if (out_data[23:16] !== 8'h33 || out_valid !== 4'b0100) begin
      errors++;
      $display("FAIL fill_head3 got d=%h v=%b want 33/0100", out_data[23:16], out_valid);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0) begin
      errors++; $display("FAIL fill_drain got %b want 0000", out_valid);
    end
    out_ready = 4'b0;
  endtask

  task automatic test_simultaneous();
    out_ready = 4'b0; set_sel(1);
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_data = 8'h55; out_ready = 4'b0010;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h55) begin
      errors++;
      $display("FAIL simul_head got v=%b d=%h want 0010/55", out_valid, out_data[15:8]);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0) begin
      errors++; $display("FAIL simul_count got %b want 0000", out_valid);
    end
    out_ready = 4'b0;
  endtask

  task automatic test_enable_reset();
    out_ready = 4'b0; en = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_sel(k); in_data = 8'hC0 + 8'(k);
      tick();
    end
    en = 1'b0; set_sel(0); in_data = 8'hEE;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL en_in_ready got %b want 0", in_ready);
    end
    tick();
    out_ready = 4'b0001;
    tick();
    checks++;
    if (out_valid !== 4'b1110) begin
      errors++; $display("FAIL en_drain got %b want 1110", out_valid);
    end
    checks++;
    if (stall_cnt !== 8'd3) begin
      errors++; $display("FAIL en_stall_frozen got %0d want 3", stall_cnt);
    end
    out_ready = 4'b0; en = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0 || busy !== 1'b0 || stall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid got v=%b busy=%b st=%0d want 0/0/0",
               out_valid, busy, stall_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_after got v=%b d=%h want 0/0", out_valid, out_data);
    end
  endtask

  task automatic test_wrap_sat();
    en = 1'b1; set_sel(3); out_ready = 4'b1000;
    in_valid = 1'b1; in_data = 8'hD0;
    tick();
    for (int i = 1; i < 10; i++) begin
      in_data = 8'hD0 + 8'(i);
      checks++;
      if (out_data[31:24] !== 8'hD0 + 8'(i - 1) || out_valid !== 4'b1000) begin
        errors++;
        $display("FAIL wrap_%0d got v=%b d=%h want 1000/%h",
                 i, out_valid, out_data[31:24], 8'hD0 + 8'(i - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_data[31:24] !== 8'hD9) begin
      errors++; $display("FAIL wrap_last got %h want d9", out_data[31:24]);
    end
    tick();
    out_ready = 4'b0; in_valid = 1'b1;
    in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    en = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (stall_cnt !== 8'd0) begin
      errors++; $display("FAIL sat_frozen got %0d want 0", stall_cnt);
    end
    en = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (stall_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_value got %0d want 255", stall_cnt);
    end
    checks++;
    if (out_data[31:24] !== 8'h01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sat_data got d=%h busy=%b want 01/1", out_data[31:24], busy);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d1 = 1'b0; d0 = 1'b0;
    in_valid = 1'b0; in_data = 8'h0; out_ready = 4'b0;
    test_reset();
    test_routing();
    test_fill_stall();
    test_simultaneous();
    test_enable_reset();
    test_wrap_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
